// File: rtl/pipeline_hazard_ctrl_if.sv
// Handshake and hazard-field bundle between the datapath and pipeline_hazard_ctrl.
// master: datapath side (drives cache handshakes and stage fields, receives stage controls).
// slave:  controller side.
interface pipeline_hazard_ctrl_if #(
    parameter int REG_AW = 5
);
    logic              imem_req;
    logic              imem_resp;
    logic              dmem_req;
    logic              dmem_resp;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_rs1_use;
    logic              id_rs2_use;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_mem_read;
    logic              br_taken;
    logic              pc_load;
    logic              ifid_load;
    logic              back_load;
    logic              ifid_flush;
    logic              idex_bubble;

    modport master (
        output imem_req, imem_resp, dmem_req, dmem_resp,
        output id_rs1, id_rs2, id_rs1_use, id_rs2_use,
        output ex_rd, ex_mem_read, br_taken,
        input  pc_load, ifid_load, back_load, ifid_flush, idex_bubble
    );

    modport slave (
        input  imem_req, imem_resp, dmem_req, dmem_resp,
        input  id_rs1, id_rs2, id_rs1_use, id_rs2_use,
        input  ex_rd, ex_mem_read, br_taken,
        output pc_load, ifid_load, back_load, ifid_flush, idex_bubble
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: turns I/D-cache handshakes, load-use hazards and
// taken-branch flushes into per-cycle load/flush/bubble controls for the stage registers.
// Optional macro PIPE_PERF_CNT_EN adds saturating stall/load-use/flush counters.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// RUN      | last cycle advanced; no cache response is being remembered
// MEM_WAIT | pipeline held waiting on a cache; done flags remember early responses
module pipeline_hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    pipeline_hazard_ctrl_if.slave    hz
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]         stall_mem_cnt,
    output logic [CNT_W-1:0]         load_use_cnt,
    output logic [CNT_W-1:0]         flush_cnt
`endif
);

    typedef enum logic {RUN, MEM_WAIT} state_e;

    state_e state_q, state_d;
    logic   imem_done_q, imem_done_d;
    logic   dmem_done_q, dmem_done_d;
    logic   i_ok, d_ok, advance, load_use;

    if (REG_AW < 1 || CNT_W < 1) begin : g_bad_param
        $error("pipeline_hazard_ctrl: REG_AW and CNT_W must be positive");
    end

    // State and response-flag registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            imem_done_q <= 1'b0;
            dmem_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            imem_done_q <= imem_done_d;
            dmem_done_q <= dmem_done_d;
        end
    end

    // Advance/hold decision, hazard priority and next-state
    always_comb begin
        state_d        = state_q;
        imem_done_d    = imem_done_q;
        dmem_done_d    = dmem_done_q;
        hz.pc_load     = 1'b0;
        hz.ifid_load   = 1'b0;
        hz.back_load   = 1'b0;
        hz.ifid_flush  = 1'b0;
        hz.idex_bubble = 1'b0;

        i_ok     = ~hz.imem_req | hz.imem_resp | imem_done_q;
        d_ok     = ~hz.dmem_req | hz.dmem_resp | dmem_done_q;
        advance  = i_ok & d_ok;
        load_use = hz.ex_mem_read & (hz.ex_rd != '0) &
                   ((hz.id_rs1_use & (hz.id_rs1 == hz.ex_rd)) |
                    (hz.id_rs2_use & (hz.id_rs2 == hz.ex_rd)));

        if (!reset) begin
            if (advance) begin
                state_d     = RUN;
                imem_done_d = 1'b0;
                dmem_done_d = 1'b0;
                if (hz.br_taken) begin
                    // Branch flush kills both younger instructions, so a load-use
                    // stall on the one in IF_ID would be pointless.
                    hz.pc_load     = 1'b1;
                    hz.ifid_load   = 1'b1;
                    hz.back_load   = 1'b1;
                    hz.ifid_flush  = 1'b1;
                    hz.idex_bubble = 1'b1;
                end else if (load_use) begin
                    hz.back_load   = 1'b1;
                    hz.idex_bubble = 1'b1;
                end else begin
                    hz.pc_load     = 1'b1;
                    hz.ifid_load   = 1'b1;
                    hz.back_load   = 1'b1;
                end
            end else begin
                // Response only counts while its request is up, so a stray pulse
                // left over from before a reset cannot satisfy a later fetch.
                state_d     = MEM_WAIT;
                imem_done_d = imem_done_q | (hz.imem_req & hz.imem_resp);
                dmem_done_d = dmem_done_q | (hz.dmem_req & hz.dmem_resp);
            end
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] lu_cnt_q, lu_cnt_d;
    logic [CNT_W-1:0] fl_cnt_q, fl_cnt_d;

    // Saturating perf-counter increments
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        lu_cnt_d    = lu_cnt_q;
        fl_cnt_d    = fl_cnt_q;
        if (!advance && stall_cnt_q != '1)
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (advance && !hz.br_taken && load_use && lu_cnt_q != '1)
            lu_cnt_d = lu_cnt_q + CNT_W'(1);
        if (advance && hz.br_taken && fl_cnt_q != '1)
            fl_cnt_d = fl_cnt_q + CNT_W'(1);
    end

    // Perf-counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            lu_cnt_q    <= '0;
            fl_cnt_q    <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            lu_cnt_q    <= lu_cnt_d;
            fl_cnt_q    <= fl_cnt_d;
        end
    end

    assign stall_mem_cnt = stall_cnt_q;
    assign load_use_cnt  = lu_cnt_q;
    assign flush_cnt     = fl_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios followed by
// randomized traffic, all compared against a cycle-level behavioural model.
module tb_pipeline_hazard_ctrl;
    localparam int REG_AW = 5;
    localparam int CNT_W  = 32;

    logic clk = 1'b0;
    logic reset;
    int   vectors    = 0;
    int   miscompares = 0;

    // Model memory: has each cache answered since the last advance?
    bit   m_i_got, m_d_got;
    longint unsigned m_stall, m_lu, m_fl;

    pipeline_hazard_ctrl_if #(.REG_AW(REG_AW)) bus ();

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_mem_cnt, load_use_cnt, flush_cnt;
`endif

    pipeline_hazard_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (bus.slave)
`ifdef PIPE_PERF_CNT_EN
        ,
        .stall_mem_cnt (stall_mem_cnt),
        .load_use_cnt  (load_use_cnt),
        .flush_cnt     (flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic bit m_advance();
        bit fetch_ready, data_ready;
        fetch_ready = !bus.imem_req || bus.imem_resp || m_i_got;
        data_ready  = !bus.dmem_req || bus.dmem_resp || m_d_got;
        return fetch_ready && data_ready;
    endfunction

    function automatic bit m_hazard();
        bit hit1, hit2;
        hit1 = bus.id_rs1_use && (bus.id_rs1 == bus.ex_rd);
        hit2 = bus.id_rs2_use && (bus.id_rs2 == bus.ex_rd);
        return bus.ex_mem_read && (bus.ex_rd != 0) && (hit1 || hit2);
    endfunction

    // Expected {pc_load, ifid_load, back_load, ifid_flush, idex_bubble}
    function automatic logic [4:0] m_out();
        if (reset)        return 5'b00000;
        if (!m_advance()) return 5'b00000;
        if (bus.br_taken) return 5'b11111;
        if (m_hazard())   return 5'b00101;
        return 5'b11100;
    endfunction

    function automatic longint unsigned sat_inc(input longint unsigned v);
        longint unsigned maxv;
        maxv = (longint'(1) << CNT_W) - 1;
        return (v >= maxv) ? maxv : v + 1;
    endfunction

    task automatic m_update();
        if (reset) begin
            m_i_got = 0; m_d_got = 0;
            m_stall = 0; m_lu = 0; m_fl = 0;
        end else if (m_advance()) begin
            if (bus.br_taken)    m_fl = sat_inc(m_fl);
            else if (m_hazard()) m_lu = sat_inc(m_lu);
            m_i_got = 0; m_d_got = 0;
        end else begin
            m_stall = sat_inc(m_stall);
            if (bus.imem_req && bus.imem_resp) m_i_got = 1;
            if (bus.dmem_req && bus.dmem_resp) m_d_got = 1;
        end
    endtask

    // One clock cycle: sample at the falling edge, compare, advance the model,
    // then return just after the rising edge so new inputs can be driven.
    task automatic tick(input string tag, input logic [4:0] exp, input bit use_exp);
        logic [4:0] act, mdl;
        @(negedge clk);
        act = {bus.pc_load, bus.ifid_load, bus.back_load, bus.ifid_flush, bus.idex_bubble};
        mdl = m_out();
        vectors++;
        assert (act === mdl) else begin
            miscompares++;
            $error("FAIL %s ctrl: observed %b expected %b", tag, act, mdl);
        end
        if (use_exp) begin
            vectors++;
            assert (act === exp) else begin
                miscompares++;
                $error("FAIL %s directed: observed %b expected %b", tag, act, exp);
            end
        end
`ifdef PIPE_PERF_CNT_EN
        vectors++;
        assert ({stall_mem_cnt, load_use_cnt, flush_cnt} ===
                {CNT_W'(m_stall), CNT_W'(m_lu), CNT_W'(m_fl)}) else begin
            miscompares++;
            $error("FAIL %s counters: observed %0d/%0d/%0d expected %0d/%0d/%0d", tag,
                   stall_mem_cnt, load_use_cnt, flush_cnt, m_stall, m_lu, m_fl);
        end
`endif
        @(posedge clk);
        m_update();
        #1;
    endtask

    task automatic idle_inputs();
        bus.imem_req = 0; bus.imem_resp = 0; bus.dmem_req = 0; bus.dmem_resp = 0;
        bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_rs1_use = 0; bus.id_rs2_use = 0;
        bus.ex_rd = 0; bus.ex_mem_read = 0; bus.br_taken = 0;
    endtask

    initial begin
        m_i_got = 0; m_d_got = 0; m_stall = 0; m_lu = 0; m_fl = 0;
        reset = 1;
        idle_inputs();
        bus.imem_req = 1; bus.imem_resp = 1;
        #1;

        // Reset held two cycles: everything quiet
        tick("reset0", 5'b00000, 1);
        tick("reset1", 5'b00000, 1);
        reset = 0;
        tick("release", 5'b11100, 1);

        // Both caches busy; I answers in cycle 2, D in cycle 5
        bus.imem_req = 1; bus.dmem_req = 1;
        for (int c = 0; c < 6; c++) begin
            bus.imem_resp = (c == 2);
            bus.dmem_resp = (c == 5);
            tick($sformatf("memwait_c%0d", c), (c == 5) ? 5'b11100 : 5'b00000, 1);
        end
        // Flags must have been dropped by the advance
        bus.imem_resp = 0; bus.dmem_resp = 0;
        tick("flags_clear", 5'b00000, 1);
        bus.imem_resp = 1; bus.dmem_resp = 1;
        tick("memwait_exit", 5'b11100, 1);

        // Load-use on rs1, then the bubble has gone through
        idle_inputs();
        bus.ex_mem_read = 1; bus.ex_rd = 5; bus.id_rs1 = 5; bus.id_rs1_use = 1;
        tick("load_use_rs1", 5'b00101, 1);
        bus.ex_mem_read = 0;
        tick("after_bubble", 5'b11100, 1);
        bus.ex_mem_read = 1; bus.ex_rd = 0; bus.id_rs1 = 0;
        tick("load_use_x0", 5'b11100, 1);
        bus.ex_rd = 7; bus.id_rs1 = 3; bus.id_rs2 = 7; bus.id_rs2_use = 1;
        tick("load_use_rs2", 5'b00101, 1);
        bus.id_rs2_use = 0;
        tick("rs2_unused", 5'b11100, 1);

        // Branch wins over load-use
        bus.ex_rd = 5; bus.id_rs1 = 5; bus.id_rs1_use = 1; bus.br_taken = 1;
        tick("br_over_lu", 5'b11111, 1);

        // Branch held while D-cache answers 3 cycles late
        idle_inputs();
        bus.br_taken = 1; bus.dmem_req = 1;
        for (int c = 0; c < 4; c++) begin
            bus.dmem_resp = (c == 3);
            tick($sformatf("br_wait_c%0d", c), (c == 3) ? 5'b11111 : 5'b00000, 1);
        end
        bus.br_taken = 0; bus.dmem_req = 0; bus.dmem_resp = 0;
        tick("br_done", 5'b11100, 1);

        // Remember an I response, then reset mid-stall
        bus.imem_req = 1; bus.imem_resp = 1; bus.dmem_req = 1;
        tick("set_idone", 5'b00000, 1);
        bus.imem_resp = 0;
        tick("hold_idone", 5'b00000, 1);
        reset = 1;
        tick("mid_reset", 5'b00000, 1);
        reset = 0; bus.dmem_req = 0;
        tick("stale_idone", 5'b00000, 1);
        bus.imem_resp = 1;
        tick("fresh_iresp", 5'b11100, 1);
        // Response with no request after reset must not latch anything
        reset = 1;
        tick("reset_again", 5'b00000, 1);
        reset = 0; bus.imem_req = 0; bus.imem_resp = 1; bus.dmem_req = 1;
        tick("resp_no_req", 5'b00000, 1);
        bus.imem_req = 1; bus.imem_resp = 0;
        tick("no_stale_flag", 5'b00000, 1);
        bus.dmem_resp = 1;
        tick("still_need_i", 5'b00000, 1);

        // Randomized traffic against the model
        for (int n = 0; n < 2000; n++) begin
            reset           = ($urandom_range(0, 63) == 0);
            bus.imem_req    = ($urandom_range(0, 3) != 0);
            bus.imem_resp   = ($urandom_range(0, 2) == 0);
            bus.dmem_req    = ($urandom_range(0, 4) < 2);
            bus.dmem_resp   = ($urandom_range(0, 2) == 0);
            bus.id_rs1      = REG_AW'($urandom_range(0, 3));
            bus.id_rs2      = REG_AW'($urandom_range(0, 3));
            bus.id_rs1_use  = $urandom_range(0, 1) != 0;
            bus.id_rs2_use  = $urandom_range(0, 1) != 0;
            bus.ex_rd       = REG_AW'($urandom_range(0, 3));
            bus.ex_mem_read = $urandom_range(0, 1) != 0;
            bus.br_taken    = ($urandom_range(0, 6) == 0);
            tick("random", 5'b00000, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
